mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, directly downstream of EX and upstream of WB.
- Registers the EX-to-MEM bus and captures the synchronous data-SRAM read data.
- Aligns and extends load data, then selects the write-back value.
- Drives the MEM-to-WB bus plus a combinational MEM-to-RF forwarding bus back to ID.

Parameters:
- EX_TO_MEM_WD, 79, width of the incoming bus: {load_op[2:0], pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}, MSB first.
- MEM_TO_WB_WD, 70, width of the outgoing bus: {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- MEM_TO_RF_WD, 38, width of the forwarding bus: {rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- STALL_W, 6, width of the stall bus.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  per-stage stop flags; 1 = stop; bit 3 = MEM register, bit 4 = WB register
- ex_to_mem_bus  in  EX_TO_MEM_WD  EX results, fields as in Parameters
- data_sram_rdata  in  32  SRAM read data, valid in the cycle after the request
- mem_to_wb_bus  out  MEM_TO_WB_WD  to the WB pipeline register
- mem_to_rf_bus  out  MEM_TO_RF_WD  forwarding path to ID
- mem_is_load  out  1  instruction in MEM is a load (data_ram_en & sel_rf_res); used by hazard detection

Behaviour:
- Pipeline register bus_r (EX_TO_MEM_WD bits), asynchronous clear on rst.
  - stall[3]=1 and stall[4]=0: load all zeros (bubble).
  - stall[3]=0: load ex_to_mem_bus.
  - stall[3]=1 and stall[4]=1: hold.
- Read-data hold:
  - rd_valid_r: 1 bit, cleared on rst, on a bubble load and on every new load of bus_r.
  - On any clock edge where bus_r is held: rd_valid_r set to 1; if rd_valid_r was 0, rd_hold_r (32 bits) captures data_sram_rdata.
  - Effective read data = rd_valid_r ? rd_hold_r : data_sram_rdata.
  - Guarantees the load result stays stable across any stall length, even if the SRAM output changes.
- Load alignment: addr = ex_result[1:0], little-endian lanes.
  - load_op 000 LW: full word, addr ignored.
  - load_op 001 LB / 010 LBU: byte lane addr[1:0], sign- or zero-extended.
  - load_op 011 LH / 100 LHU: halfword lane addr[1] (low half when 0, high half when 1), addr[0] ignored, sign- or zero-extended.
  - load_op 101-111: treated as LW.
  - No misalignment exceptions.
- Write-back select: rf_wdata = sel_rf_res ? aligned load data : ex_result.
- Output buses are combinational from bus_r and the effective read data.
  - mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata}.
  - mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata}.
- Zero latency inside the stage; EX-to-WB bus latency is one clock via bus_r.
- Reset, including mid-stall: bus_r, rd_valid_r and rd_hold_r cleared immediately. All outputs read 0 (rf_we=0, mem_is_load=0) until the first post-reset capture.
- Stores (data_ram_wen≠0, rf_we=0) pass through with rf_we=0. No data-SRAM outputs are driven here; EX owns the SRAM request.

Test Plan:
- LW, ex_result=0x100, SRAM returns 0xDEADBEEF next cycle -> mem_to_wb_bus rf_wdata=0xDEADBEEF, rf_we=1, same cycle bus_r updates.
- LB at addr 0x103, data 0x80FF1234 -> rf_wdata=0xFFFFFF80; LBU same -> 0x00000080; LH at addr 0x102 -> 0xFFFF80FF; LHU -> 0x000080FF.
- LW enters MEM, stall[3]=stall[4]=1 for 3 cycles while data_sram_rdata changes 0x11111111 -> 0x22222222 -> 0x33333333 -> rf_wdata stays 0x11111111 throughout, then the next instruction loads normally.
- stall[3]=1, stall[4]=0 with valid ex_to_mem_bus -> next cycle mem_to_wb_bus=0, mem_is_load=0, rd_valid_r=0.
- ALU op, sel_rf_res=0, ex_result=0x0000002A, rf_waddr=5 -> mem_to_rf_bus={1,5,0x2A} combinationally in the cycle it is in MEM.
- Assert rst asynchronously mid-stall holding a load -> outputs drop to 0 before the next clk edge; after release the first instruction behaves as in the LW scenario.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: registers the EX bus and aligns/extends SRAM load data into the WB and forwarding buses.
// One clock from EX to the WB bus via bus_r; stall[3]&stall[4] holds the stage and freezes read data, stall[3] alone inserts a bubble.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_RF_WD = 38,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    mem_is_load
);

  typedef struct packed {
    logic [2:0]  load_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic                    rd_valid_r;
  logic [31:0]             rd_hold_r;

  ex_mem_t     w_f;
  logic        w_hold;
  logic        w_bubble;
  logic [31:0] w_rdata;
  logic [1:0]  w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wdata;

  assign w_f      = ex_mem_t'(bus_r);
  assign w_hold   = stall[3] & stall[4];
  assign w_bubble = stall[3] & ~stall[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r      <= '0;
      rd_valid_r <= 1'b0;
      rd_hold_r  <= 32'h0;
    end else if (!stall[3]) begin
      bus_r      <= ex_to_mem_bus;
      rd_valid_r <= 1'b0;
    end else if (w_bubble) begin
      bus_r      <= '0;
      rd_valid_r <= 1'b0;
    end else if (w_hold) begin
      // First held edge snapshots the SRAM word; later edges keep it even if the SRAM output moves.
      rd_valid_r <= 1'b1;
      if (!rd_valid_r) rd_hold_r <= data_sram_rdata;
    end
  end

  assign w_rdata = rd_valid_r ? rd_hold_r : data_sram_rdata;
  assign w_addr  = w_f.ex_result[1:0];

  always_comb begin
    w_byte = 8'h0;
    case (w_addr)
      2'd0: w_byte = w_rdata[7:0];
      2'd1: w_byte = w_rdata[15:8];
      2'd2: w_byte = w_rdata[23:16];
      2'd3: w_byte = w_rdata[31:24];
      default: w_byte = 8'h0;
    endcase
    w_half = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
    case (w_f.load_op)
      3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load = {24'h0, w_byte};
      3'b011:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {16'h0, w_half};
      default: w_load = w_rdata;
    endcase
  end

  assign w_wdata       = w_f.sel_rf_res ? w_load : w_f.ex_result;
  assign mem_to_wb_bus = {w_f.pc, w_f.rf_we, w_f.rf_waddr, w_wdata};
  assign mem_to_rf_bus = {w_f.rf_we, w_f.rf_waddr, w_wdata};
  assign mem_is_load   = w_f.data_ram_en & w_f.sel_rf_res;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, stall hold/bubble, forwarding and async reset.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        mem_is_load;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .mem_is_load     (mem_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [78:0] mk_bus(input logic [2:0] op, input logic [31:0] pc,
                                         input logic en, input logic [3:0] wen, input logic sel,
                                         input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, en, wen, sel, we, wa, res};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  ops  [8];
  logic [31:0] adrs [8];
  logic [31:0] exps [8];

  initial begin
    ops[0] = 3'b001; adrs[0] = 32'h103; exps[0] = 32'hFFFFFF80;
    ops[1] = 3'b010; adrs[1] = 32'h103; exps[1] = 32'h00000080;
    ops[2] = 3'b011; adrs[2] = 32'h102; exps[2] = 32'hFFFF80FF;
    ops[3] = 3'b100; adrs[3] = 32'h102; exps[3] = 32'h000080FF;
    ops[4] = 3'b001; adrs[4] = 32'h100; exps[4] = 32'h00000034;
    ops[5] = 3'b011; adrs[5] = 32'h101; exps[5] = 32'h00001234;
    ops[6] = 3'b111; adrs[6] = 32'h103; exps[6] = 32'h80FF1234;
    ops[7] = 3'b010; adrs[7] = 32'h102; exps[7] = 32'h000000FF;

    rst = 1'b1; stall = 6'h0; ex_to_mem_bus = '0; data_sram_rdata = 32'h0;
    #8;
    chk("reset_wb", {10'h0, mem_to_wb_bus}, 80'h0);
    chk("reset_rf", {42'h0, mem_to_rf_bus}, 80'h0);
    chk("reset_is_load", {79'h0, mem_is_load}, 80'h0);
    rst = 1'b0;

    // LW at 0x100, SRAM answers the following cycle
    ex_to_mem_bus = mk_bus(3'b000, 32'h1000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h100);
    edge1();
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_wb", {10'h0, mem_to_wb_bus}, {10'h0, 32'h1000, 1'b1, 5'd3, 32'hDEADBEEF});
    chk("lw_is_load", {79'h0, mem_is_load}, 80'h1);

    for (int i = 0; i < 8; i++) begin
      ex_to_mem_bus = mk_bus(ops[i], 32'h1100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, adrs[i]);
      data_sram_rdata = 32'h0;
      edge1();
      data_sram_rdata = 32'h80FF1234;
      #1;
      chk($sformatf("align_%0d", i), {48'h0, mem_to_wb_bus[31:0]}, {48'h0, exps[i]});
    end

    // LW held for three cycles while the SRAM output wanders
    ex_to_mem_bus = mk_bus(3'b000, 32'h2000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h200);
    data_sram_rdata = 32'h0;
    edge1();
    data_sram_rdata = 32'h11111111;
    stall = 6'b011000;
    ex_to_mem_bus = mk_bus(3'b000, 32'h2004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h204);
    #1;
    chk("hold_pre", {10'h0, mem_to_wb_bus}, {10'h0, 32'h2000, 1'b1, 5'd7, 32'h11111111});
    edge1(); data_sram_rdata = 32'h22222222; #1;
    chk("hold_1", {10'h0, mem_to_wb_bus}, {10'h0, 32'h2000, 1'b1, 5'd7, 32'h11111111});
    edge1(); data_sram_rdata = 32'h33333333; #1;
    chk("hold_2", {10'h0, mem_to_wb_bus}, {10'h0, 32'h2000, 1'b1, 5'd7, 32'h11111111});
    edge1(); data_sram_rdata = 32'h44444444; #1;
    chk("hold_3", {10'h0, mem_to_wb_bus}, {10'h0, 32'h2000, 1'b1, 5'd7, 32'h11111111});
    stall = 6'h0;
    edge1();
    data_sram_rdata = 32'h55555555;
    #1;
    chk("after_hold", {10'h0, mem_to_wb_bus}, {10'h0, 32'h2004, 1'b1, 5'd8, 32'h55555555});

    // ALU result forwarded combinationally
    ex_to_mem_bus = mk_bus(3'b000, 32'h2008, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0000002A);
    edge1();
    chk("alu_rf", {42'h0, mem_to_rf_bus}, {42'h0, 1'b1, 5'd5, 32'h0000002A});
    chk("alu_not_load", {79'h0, mem_is_load}, 80'h0);

    // Store passes through without a register write
    ex_to_mem_bus = mk_bus(3'b000, 32'h200C, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h300);
    edge1();
    chk("store_wb", {10'h0, mem_to_wb_bus}, {10'h0, 32'h200C, 1'b0, 5'd0, 32'h300});

    // Bubble: stall MEM but not WB
    ex_to_mem_bus = mk_bus(3'b000, 32'h2010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h104);
    stall = 6'b001000;
    edge1();
    chk("bubble_wb", {10'h0, mem_to_wb_bus}, 80'h0);
    chk("bubble_is_load", {79'h0, mem_is_load}, 80'h0);
    chk("bubble_rd_valid", {79'h0, dut.rd_valid_r}, 80'h0);

    // Async reset while a load is held
    stall = 6'h0;
    ex_to_mem_bus = mk_bus(3'b000, 32'h3000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h108);
    edge1();
    data_sram_rdata = 32'h77777777;
    stall = 6'b011000;
    edge1();
    chk("rst_pre", {48'h0, mem_to_wb_bus[31:0]}, {48'h0, 32'h77777777});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wb", {10'h0, mem_to_wb_bus}, 80'h0);
    chk("rst_mid_is_load", {79'h0, mem_is_load}, 80'h0);
    #2 rst = 1'b0;
    stall = 6'h0;
    ex_to_mem_bus = mk_bus(3'b000, 32'h4000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h100);
    edge1();
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("post_rst_lw", {10'h0, mem_to_wb_bus}, {10'h0, 32'h4000, 1'b1, 5'd3, 32'hDEADBEEF});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
